issue_queue: RTL
================

Name: issue_queue

Overview:
- Parametrised out-of-order instruction queue built on the shared instruction-queue entry type.
- Sits between rename/dispatch and the execute stage.
- Holds up to DEPTH renamed instructions and tracks per-operand readiness through tag-broadcast wakeup.
- Issues the oldest ready entry each cycle over a valid/ready handshake, and supports a whole-queue flush on branch mispredict.

Parameters:
- DEPTH, 8: number of entries; power of two, 2..32.
- PREG_W, 6: physical register tag width. Matches the MipsReg width; the package tag type is sized by it.
- NUM_WAKEUP, 2: number of result-tag broadcast ports per cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- dispatch_valid  in  1  incoming entry is valid.
- dispatch_ready  out  1  queue can accept an entry this cycle.
- dispatch_entry  in  Instr_Queue_Entry_t  renamed instruction; its valid, ready and count fields are ignored.
- dispatch_rs_rdy  in  1  rs operand already available at dispatch.
- dispatch_rt_rdy  in  1  rt operand already available at dispatch.
- wakeup_valid  in  NUM_WAKEUP  per-port broadcast valid.
- wakeup_tag  in  NUM_WAKEUP*PREG_W  packed producer tags; port k occupies bits [k*PREG_W +: PREG_W].
- issue_valid  out  1  issue_entry holds a ready instruction.
- issue_ready  in  1  execute stage accepts.
- issue_entry  out  Instr_Queue_Entry_t  selected entry; ready=1, count=dispatch stamp.
- flush  in  1  mispredict; discard all entries.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (rst high at posedge):
  - All entries invalid, age matrix cleared, dispatch stamp = 0, occupancy = 0.
  - While rst is high, issue_valid = 0 and dispatch_ready = 0.
- Dispatch fire = dispatch_valid && dispatch_ready.
  - On a fire, the entry is written into the lowest-index free slot at the clock edge.
  - The entry becomes visible to select the following cycle (minimum dispatch-to-issue latency 1).
- dispatch_ready = (occupancy < DEPTH) && !flush. No same-cycle credit is taken from an issue.
- Per-entry source ready bits:
  - rs_rdy is set on dispatch from dispatch_rs_rdy, or from a same-cycle wakeup match on dispatch_entry.rs_phys.
  - rt_rdy is handled the same way against rt_phys.
  - An unused source (uses_rs/uses_rt = 0) is treated as ready.
- Wakeup: for each valid port k, every valid entry whose rs_phys/rt_phys equals tag k sets the matching ready bit at the edge. Tag 0 (zero) is always ready.
- Entry ready = valid && (rs_rdy || !uses_rs) && (rt_rdy || !uses_rt).
  - Select is combinational on registered state; there is no wakeup-to-issue bypass in the same cycle.
- Age ordering: DEPTH x DEPTH matrix, older[i][j] = 1 when entry i was dispatched before entry j.
  - Set when the row is written; the column is cleared when an entry leaves.
  - Select picks the ready entry with no older ready entry, so exactly one or zero entries are chosen.
- Issue fire = issue_valid && issue_ready. The selected entry is invalidated at the edge.
  - If issue_ready is low, the selection may change next cycle, e.g. when an older entry wakes up. issue_entry is not held stable.
- Simultaneous dispatch and issue: both apply; occupancy is unchanged. A freed slot is reusable only the next cycle.
- Flush:
  - issue_valid is forced 0 during the flush cycle.
  - All entries are cleared at the edge.
  - Flush has priority over dispatch, issue and wakeup.
  - The dispatch stamp is not reset by flush.
- count field: overwritten with a free-running 32-bit dispatch stamp that increments on each dispatch fire and wraps modulo 2^32. It is for debug and trace only and is not used for ordering.
- Full: at occupancy = DEPTH, dispatch_ready = 0. Empty: issue_valid = 0.

Optional Feature:
- Macro ISSUE_QUEUE_STATS_EN.
- When defined, three 32-bit saturating counters are added:
  - full_stall_cycles: dispatch_valid && !dispatch_ready.
  - issue_cycles: issue fire.
  - empty_cycles: occupancy == 0.
- The counters reset on rst, are not cleared by flush, and are exposed as output ports stat_full, stat_issue and stat_empty.
- When the macro is undefined, these ports and the counter logic do not exist.

Decomposition:
- mips_core_pkg:
  - Instr_Queue_Entry_t; rs_phys/rt_phys/rw_phys become a PREG_W-wide tag type.
  - IQ_DEFAULT_DEPTH constant.
  - localparam STAMP_W = 32.
- Sub-module iq_age_select:
  - Inputs: DEPTH-bit ready vector and the age matrix.
  - Outputs: one-hot grant and grant_valid.
  - Purely combinational, unit-testable in isolation.

Test Plan:
1. Dispatch add, uses_rs=1, rs_phys=9, dispatch_rs_rdy=0 -> issue_valid stays 0. Then wakeup_tag[0]=9 -> issue_valid=1 exactly one cycle later, count=0.
2. Dispatch A(stamp 0), B(1), C(2), all ready; issue_ready held low until all three are resident, then held high -> issue order A,B,C on three consecutive cycles, occupancy 3->2->1->0.
3. Fill DEPTH=8 entries -> dispatch_ready=0 at occupancy 8. One issue fire -> dispatch_ready=1 the next cycle.
4. Same-cycle dispatch with rt_phys=12 and wakeup_tag[1]=12 -> entry issues the next cycle, not stuck waiting.
5. 5 entries resident, flush=1 together with dispatch_valid=1 and issue_ready=1 -> issue_valid=0 that cycle, occupancy=0 next cycle, dispatched entry dropped.
6. rst asserted with 4 entries resident -> next cycle occupancy=0, issue_valid=0; dispatch_ready returns to 1 once rst deasserts.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: instruction-queue entry, physical register tag and
// issue-queue defaults.
package mips_core_pkg;

  localparam int unsigned MIPS_PREG_W      = 6;
  localparam int unsigned STAMP_W          = 32;
  localparam int unsigned IQ_DEFAULT_DEPTH = 8;

  typedef logic [MIPS_PREG_W-1:0] preg_t;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [STAMP_W-1:0] count;
    logic [31:0]        instr;
    logic               uses_rs;
    logic               uses_rt;
    preg_t              rs_phys;
    preg_t              rt_phys;
    preg_t              rw_phys;
  } Instr_Queue_Entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is
// older than. older[j*DEPTH+i] = 1 means entry j was dispatched before entry i.
module iq_age_select #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*DEPTH-1:0] older,
  output logic [DEPTH-1:0]       grant,
  output logic                   grant_valid
);

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j*DEPTH+i]) grant[i] = 1'b0;
      end
    end
  end

  assign grant_valid = |grant;

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue with tag-broadcast wakeup and age-matrix select.
// Optional ISSUE_QUEUE_STATS_EN adds stall/issue/empty saturating counters.
module issue_queue
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH      = IQ_DEFAULT_DEPTH,
  parameter int unsigned PREG_W     = MIPS_PREG_W,
  parameter int unsigned NUM_WAKEUP = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  Instr_Queue_Entry_t           dispatch_entry,
  input  logic                         dispatch_rs_rdy,
  input  logic                         dispatch_rt_rdy,
  input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_tag,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output Instr_Queue_Entry_t           issue_entry,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0]                  stat_full,
  output logic [31:0]                  stat_issue,
  output logic [31:0]                  stat_empty
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  Instr_Queue_Entry_t       ent_q [DEPTH];
  logic [DEPTH-1:0]         valid_q, rs_rdy_q, rt_rdy_q;
  logic [DEPTH*DEPTH-1:0]   older_q;
  logic [OCC_W-1:0]         occ_q;
  logic [STAMP_W-1:0]       stamp_q;

  logic [DEPTH-1:0]         ready_vec, grant, free_oh, wake_rs, wake_rt;
  logic                     grant_valid, free_found;
  logic                     dispatch_fire, issue_fire;
  logic                     disp_rs_rdy, disp_rt_rdy;
  Instr_Queue_Entry_t       disp_ent;
  preg_t                    wtag [NUM_WAKEUP];

  always_comb begin
    for (int unsigned k = 0; k < NUM_WAKEUP; k++)
      wtag[k] = preg_t'(wakeup_tag[k*PREG_W +: PREG_W]);
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++)
      ready_vec[i] = valid_q[i] && (rs_rdy_q[i] || !ent_q[i].uses_rs)
                                && (rt_rdy_q[i] || !ent_q[i].uses_rt);
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age_select (
    .ready       (ready_vec),
    .older       (older_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign issue_valid    = grant_valid && !flush && !rst;
  assign dispatch_ready = (occ_q < OCC_W'(DEPTH)) && !flush && !rst;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;
  assign issue_fire     = issue_valid && issue_ready;
  assign occupancy      = occ_q;

  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    issue_entry = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (grant[i]) issue_entry = ent_q[i];
    issue_entry.valid = issue_valid;
    issue_entry.ready = 1'b1;
  end

  // Source readiness at dispatch also catches a same-cycle broadcast.
  always_comb begin
    disp_ent       = dispatch_entry;
    disp_ent.valid = 1'b1;
    disp_ent.ready = 1'b0;
    disp_ent.count = stamp_q;
    disp_rs_rdy = dispatch_rs_rdy || !dispatch_entry.uses_rs || (dispatch_entry.rs_phys == '0);
    disp_rt_rdy = dispatch_rt_rdy || !dispatch_entry.uses_rt || (dispatch_entry.rt_phys == '0);
    for (int unsigned k = 0; k < NUM_WAKEUP; k++) begin
      if (wakeup_valid[k] && dispatch_entry.rs_phys == wtag[k]) disp_rs_rdy = 1'b1;
      if (wakeup_valid[k] && dispatch_entry.rt_phys == wtag[k]) disp_rt_rdy = 1'b1;
    end
  end

  always_comb begin
    wake_rs = '0;
    wake_rt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned k = 0; k < NUM_WAKEUP; k++) begin
        if (wakeup_valid[k] && ent_q[i].rs_phys == wtag[k]) wake_rs[i] = 1'b1;
        if (wakeup_valid[k] && ent_q[i].rt_phys == wtag[k]) wake_rt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      older_q  <= '0;
      occ_q    <= '0;
      stamp_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      rs_rdy_q <= rs_rdy_q | wake_rs;
      rt_rdy_q <= rt_rdy_q | wake_rt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (issue_fire && grant[i]) begin
          valid_q[i] <= 1'b0;
          for (int unsigned j = 0; j < DEPTH; j++) begin
            older_q[i*DEPTH+j] <= 1'b0;
            older_q[j*DEPTH+i] <= 1'b0;
          end
        end
        // Written after the issue clear so the new column wins for this slot.
        if (dispatch_fire && free_oh[i]) begin
          ent_q[i]    <= disp_ent;
          valid_q[i]  <= 1'b1;
          rs_rdy_q[i] <= disp_rs_rdy;
          rt_rdy_q[i] <= disp_rt_rdy;
          for (int unsigned j = 0; j < DEPTH; j++) begin
            older_q[i*DEPTH+j] <= 1'b0;
            older_q[j*DEPTH+i] <= valid_q[j] && !(issue_fire && grant[j]);
          end
        end
      end
      if (dispatch_fire) stamp_q <= stamp_q + STAMP_W'(1);
      case ({dispatch_fire, issue_fire})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: ;
      endcase
    end
  end

`ifdef ISSUE_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_full  <= '0;
      stat_issue <= '0;
      stat_empty <= '0;
    end else begin
      if (dispatch_valid && !dispatch_ready && stat_full != '1) stat_full <= stat_full + 32'd1;
      if (issue_fire && stat_issue != '1) stat_issue <= stat_issue + 32'd1;
      if (occ_q == '0 && stat_empty != '1) stat_empty <= stat_empty + 32'd1;
    end
  end
`endif

endmodule
